// File: rtl/branch_predictor.sv
// branch_predictor: fetch-side direct-mapped BTB with 2-bit saturating
// counters. Produces registered predictions for a two-slot fetch group
// (slot a = IF_pc, slot b = IF_pc+4) and trains from the EX resolution stream.
//
// Handshake: a request is accepted at a rising edge where IF_req=1 and
// IF_stall=0; the registered outputs then carry IF_pd_valid=1 until the next
// accepting or non-requesting edge. IF_stall=1 freezes every output register.
// Updates (EX_pd_type != 00) are written at the edge they are sampled,
// regardless of IF_stall; a lookup at that same edge sees the old contents.
module branch_predictor #(
   parameter int BTB_IDX_W = 6,
   parameter int TAG_W     = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] IF_pc,
   input  logic        IF_req,
   input  logic        IF_stall,
   input  logic [31:0] EX_pc_of_br,
   input  logic [1:0]  EX_pd_type,
   input  logic [31:0] EX_br_target,
   input  logic        EX_br_jump,
   output logic        IF_pd_valid,
   output logic        IF_br_pd_a,
   output logic        IF_br_pd_b,
   output logic [31:0] IF_pc_pd_a,
   output logic [31:0] IF_pc_pd_b,
   output logic [1:0]  IF_pd_type_a,
   output logic [1:0]  IF_pd_type_b,
   output logic [31:0] IF_npc
);

   localparam int ENTRIES = 1 << BTB_IDX_W;
   localparam int TAG_LO  = BTB_IDX_W + 2;
   localparam int TAG_HI  = TAG_W + BTB_IDX_W + 1;

   // BTB storage
   logic [ENTRIES-1:0] btb_valid;
   logic [TAG_W-1:0]   btb_tag    [ENTRIES];
   logic [31:0]        btb_target [ENTRIES];
   logic [1:0]         btb_type   [ENTRIES];
   logic [1:0]         btb_cnt    [ENTRIES];

   // Lookup signals
   logic [31:0]          pc_a, pc_b, pc_plus8;
   logic [BTB_IDX_W-1:0] idx_a, idx_b;
   logic [TAG_W-1:0]     tag_a, tag_b;
   logic                 hit_a, hit_b, taken_a, taken_b_raw;
   logic                 br_a_n, br_b_n;
   logic [31:0]          pc_pd_a_n, pc_pd_b_n, npc_n;
   logic [1:0]           type_a_n, type_b_n;

   // Update signals
   logic [BTB_IDX_W-1:0] u_idx;
   logic [TAG_W-1:0]     u_tag;
   logic                 u_hit;
   logic [1:0]           u_cnt_hit, u_cnt_alloc;

   // PC bits outside index/tag carry no information for the table
   logic unused_ex_pc;
   assign unused_ex_pc = ^{EX_pc_of_br[31:TAG_HI+1], EX_pc_of_br[1:0]};

   // Parallel two-port lookup of both slots against the current table contents
   always_comb begin
      pc_a        = IF_pc;
      pc_b        = IF_pc + 32'd4;
      pc_plus8    = IF_pc + 32'd8;
      idx_a       = pc_a[BTB_IDX_W+1:2];
      idx_b       = pc_b[BTB_IDX_W+1:2];
      tag_a       = pc_a[TAG_HI:TAG_LO];
      tag_b       = pc_b[TAG_HI:TAG_LO];
      hit_a       = btb_valid[idx_a] && (btb_tag[idx_a] == tag_a);
      hit_b       = btb_valid[idx_b] && (btb_tag[idx_b] == tag_b);
      taken_a     = hit_a && btb_cnt[idx_a][1];
      taken_b_raw = hit_b && btb_cnt[idx_b][1];

      br_a_n    = taken_a;
      pc_pd_a_n = taken_a ? btb_target[idx_a] : pc_b;
      type_a_n  = hit_a ? btb_type[idx_a] : 2'b00;

      // A taken slot a means slot b is never executed
      br_b_n    = 1'b0;
      pc_pd_b_n = pc_plus8;
      type_b_n  = 2'b00;
      if (!taken_a) begin
         br_b_n    = taken_b_raw;
         pc_pd_b_n = taken_b_raw ? btb_target[idx_b] : pc_plus8;
         type_b_n  = hit_b ? btb_type[idx_b] : 2'b00;
      end

      npc_n = taken_a ? pc_pd_a_n : (taken_b_raw ? pc_pd_b_n : pc_plus8);
   end

   // Decode the EX update: entry lookup and next counter values
   always_comb begin
      u_idx = EX_pc_of_br[BTB_IDX_W+1:2];
      u_tag = EX_pc_of_br[TAG_HI:TAG_LO];
      u_hit = btb_valid[u_idx] && (btb_tag[u_idx] == u_tag);

      u_cnt_hit = 2'b11;
      if (EX_pd_type == 2'b01) begin
         if (EX_br_jump)
            u_cnt_hit = (btb_cnt[u_idx] == 2'b11) ? 2'b11 : btb_cnt[u_idx] + 2'd1;
         else
            u_cnt_hit = (btb_cnt[u_idx] == 2'b00) ? 2'b00 : btb_cnt[u_idx] - 2'd1;
      end
      u_cnt_alloc = (EX_pd_type == 2'b01) ? 2'b10 : 2'b11;
   end

   // Table write: train on hit, allocate on taken miss, ignore not-taken miss
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         btb_valid <= '0;
         for (int i = 0; i < ENTRIES; i++) begin
            btb_tag[i]    <= '0;
            btb_target[i] <= '0;
            btb_type[i]   <= 2'b00;
            btb_cnt[i]    <= 2'b01;
         end
      end else if (EX_pd_type != 2'b00) begin
         if (u_hit) begin
            btb_cnt[u_idx]    <= u_cnt_hit;
            btb_target[u_idx] <= EX_br_target;
            btb_type[u_idx]   <= EX_pd_type;
         end else if (EX_br_jump) begin
            btb_valid[u_idx]  <= 1'b1;
            btb_tag[u_idx]    <= u_tag;
            btb_target[u_idx] <= EX_br_target;
            btb_type[u_idx]   <= EX_pd_type;
            btb_cnt[u_idx]    <= u_cnt_alloc;
         end
      end
   end

   // Prediction output registers: capture on request, hold on stall
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         IF_pd_valid  <= 1'b0;
         IF_br_pd_a   <= 1'b0;
         IF_br_pd_b   <= 1'b0;
         IF_pc_pd_a   <= '0;
         IF_pc_pd_b   <= '0;
         IF_pd_type_a <= 2'b00;
         IF_pd_type_b <= 2'b00;
         IF_npc       <= '0;
      end else if (!IF_stall) begin
         if (IF_req) begin
            IF_pd_valid  <= 1'b1;
            IF_br_pd_a   <= br_a_n;
            IF_br_pd_b   <= br_b_n;
            IF_pc_pd_a   <= pc_pd_a_n;
            IF_pc_pd_b   <= pc_pd_b_n;
            IF_pd_type_a <= type_a_n;
            IF_pd_type_b <= type_b_n;
            IF_npc       <= npc_n;
         end else begin
            IF_pd_valid  <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_branch_predictor.sv
// Testbench for branch_predictor: directed vectors, expected predictions
// queued by the driver and checked by a negedge monitor.
module tb_branch_predictor;

   localparam int W = 102;

   logic        clk, rst;
   logic [31:0] IF_pc;
   logic        IF_req, IF_stall;
   logic [31:0] EX_pc_of_br;
   logic [1:0]  EX_pd_type;
   logic [31:0] EX_br_target;
   logic        EX_br_jump;
   logic        IF_pd_valid, IF_br_pd_a, IF_br_pd_b;
   logic [31:0] IF_pc_pd_a, IF_pc_pd_b, IF_npc;
   logic [1:0]  IF_pd_type_a, IF_pd_type_b;

   logic [W-1:0] exp_q[$];
   int n_vec = 0;
   int n_mis = 0;

   branch_predictor dut (
      .clk(clk), .rst(rst),
      .IF_pc(IF_pc), .IF_req(IF_req), .IF_stall(IF_stall),
      .EX_pc_of_br(EX_pc_of_br), .EX_pd_type(EX_pd_type),
      .EX_br_target(EX_br_target), .EX_br_jump(EX_br_jump),
      .IF_pd_valid(IF_pd_valid),
      .IF_br_pd_a(IF_br_pd_a), .IF_br_pd_b(IF_br_pd_b),
      .IF_pc_pd_a(IF_pc_pd_a), .IF_pc_pd_b(IF_pc_pd_b),
      .IF_pd_type_a(IF_pd_type_a), .IF_pd_type_b(IF_pd_type_b),
      .IF_npc(IF_npc)
   );

   // Clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [W-1:0] pk(input logic ba, input logic bb,
                                       input logic [1:0] ta, input logic [1:0] tb,
                                       input logic [31:0] pa, input logic [31:0] pb,
                                       input logic [31:0] np);
      return {ba, bb, ta, tb, pa, pb, np};
   endfunction

   // Both slots miss (or not taken with no hit)
   function automatic logic [W-1:0] nt(input logic [31:0] pc);
      return pk(1'b0, 1'b0, 2'b00, 2'b00, pc + 32'd4, pc + 32'd8, pc + 32'd8);
   endfunction

   function automatic logic [W-1:0] actual();
      return {IF_br_pd_a, IF_br_pd_b, IF_pd_type_a, IF_pd_type_b,
              IF_pc_pd_a, IF_pc_pd_b, IF_npc};
   endfunction

   // Monitor: every cycle with valid outputs consumes one expectation
   always @(negedge clk) begin
      if (!rst && IF_pd_valid) begin
         n_vec++;
         if (exp_q.size() == 0) begin
            n_mis++;
            $display("FAIL unexpected_valid got %h required none", actual());
         end else begin
            logic [W-1:0] e;
            e = exp_q.pop_front();
            if (actual() !== e) begin
               n_mis++;
               $display("FAIL pred_vec%0d got %h required %h", n_vec, actual(), e);
            end
         end
      end
   end

   task automatic chk(input string name, input logic [W:0] got, input logic [W:0] req);
      n_vec++;
      if (got !== req) begin
         n_mis++;
         $display("FAIL %s got %h required %h", name, got, req);
      end
   endtask

   // Present an EX update for the next edge
   task automatic set_upd(input logic [31:0] pc, input logic [1:0] ty,
                          input logic [31:0] tgt, input logic j);
      EX_pc_of_br  = pc;
      EX_pd_type   = ty;
      EX_br_target = tgt;
      EX_br_jump   = j;
   endtask

   // One clock: drive IF inputs, optionally queue the expected prediction
   task automatic cyc(input logic req, input logic stall, input logic [31:0] pc,
                      input logic push, input logic [W-1:0] e);
      IF_req   = req;
      IF_stall = stall;
      IF_pc    = pc;
      if (push) exp_q.push_back(e);
      @(posedge clk);
      #1;
      IF_req     = 1'b0;
      IF_stall   = 1'b0;
      EX_pd_type = 2'b00;
      EX_br_jump = 1'b0;
   endtask

   task automatic req(input logic [31:0] pc, input logic [W-1:0] e);
      cyc(1'b1, 1'b0, pc, 1'b1, e);
   endtask

   task automatic idle();
      cyc(1'b0, 1'b0, 32'h0, 1'b0, '0);
   endtask

   logic [W-1:0] e_t;

   initial begin
      rst = 1'b1;
      IF_pc = '0; IF_req = 1'b0; IF_stall = 1'b0;
      EX_pc_of_br = '0; EX_pd_type = 2'b00; EX_br_target = '0; EX_br_jump = 1'b0;
      e_t = pk(1'b1, 1'b0, 2'b01, 2'b00, 32'h1C000100, 32'h1C000018, 32'h1C000100);

      #12;
      chk("reset_outputs", {IF_pd_valid, actual()}, '0);
      @(negedge clk);
      rst = 1'b0;

      // Allocate, predict, then asynchronous reset mid-run
      set_upd(32'h1C000010, 2'b01, 32'h1C000100, 1'b1);
      idle();
      req(32'h1C000010, e_t);
      @(negedge clk);
      #1 rst = 1'b1;
      #1 chk("async_reset_outputs", {IF_pd_valid, actual()}, '0);
      @(negedge clk);
      rst = 1'b0;
      req(32'h1C000000, nt(32'h1C000000));
      req(32'h1C000010, nt(32'h1C000010));

      // Allocate and saturate
      set_upd(32'h1C000010, 2'b01, 32'h1C000100, 1'b1);
      idle();
      req(32'h1C000010, e_t);
      set_upd(32'h1C000010, 2'b01, 32'h1C000100, 1'b0);
      idle();
      set_upd(32'h1C000010, 2'b01, 32'h1C000100, 1'b0);
      idle();
      req(32'h1C000010, pk(1'b0, 1'b0, 2'b01, 2'b00, 32'h1C000014, 32'h1C000018, 32'h1C000018));
      for (int i = 0; i < 3; i++) begin
         set_upd(32'h1C000010, 2'b01, 32'h1C000100, 1'b1);
         idle();
      end
      set_upd(32'h1C000010, 2'b01, 32'h1C000100, 1'b0);
      idle();
      req(32'h1C000010, e_t);

      // Slot b hit, alias miss, slot a taken suppresses slot b
      set_upd(32'h1C000024, 2'b10, 32'h1C000200, 1'b1);
      idle();
      req(32'h1C000020, pk(1'b0, 1'b1, 2'b00, 2'b10, 32'h1C000024, 32'h1C000200, 32'h1C000200));
      req(32'h1C001024, nt(32'h1C001024));
      set_upd(32'h1C000028, 2'b11, 32'h1C000300, 1'b1);
      idle();
      req(32'h1C000024, pk(1'b1, 1'b0, 2'b10, 2'b00, 32'h1C000200, 32'h1C00002C, 32'h1C000200));

      // Not-taken miss is not allocated
      set_upd(32'h1C000040, 2'b01, 32'h1C000500, 1'b0);
      idle();
      req(32'h1C000040, nt(32'h1C000040));

      // Stall holds outputs while the displayed entry is retrained
      req(32'h1C000010, e_t);
      set_upd(32'h1C000010, 2'b01, 32'h1C000100, 1'b0);
      cyc(1'b1, 1'b1, 32'h1C000300, 1'b1, e_t);
      set_upd(32'h1C000010, 2'b01, 32'h1C000100, 1'b0);
      cyc(1'b1, 1'b1, 32'h1C000400, 1'b1, e_t);
      cyc(1'b1, 1'b1, 32'h1C000500, 1'b1, e_t);
      req(32'h1C000010, pk(1'b0, 1'b0, 2'b01, 2'b00, 32'h1C000014, 32'h1C000018, 32'h1C000018));

      // Same-edge request and update: old contents returned, slot a then slot b
      set_upd(32'h1C000080, 2'b10, 32'h1C000600, 1'b1);
      req(32'h1C000080, nt(32'h1C000080));
      req(32'h1C000080, pk(1'b1, 1'b0, 2'b10, 2'b00, 32'h1C000600, 32'h1C000088, 32'h1C000600));
      set_upd(32'h1C0000C4, 2'b11, 32'h1C000700, 1'b1);
      req(32'h1C0000C0, nt(32'h1C0000C0));
      req(32'h1C0000C0, pk(1'b0, 1'b1, 2'b00, 2'b11, 32'h1C0000C4, 32'h1C000700, 32'h1C000700));

      // Wrap-around
      req(32'hFFFFFFF8, pk(1'b0, 1'b0, 2'b00, 2'b00, 32'hFFFFFFFC, 32'h00000000, 32'h00000000));

      // No request drops valid; stall keeps it low
      idle();
      chk("idle_valid", {{W{1'b0}}, IF_pd_valid}, '0);
      cyc(1'b1, 1'b1, 32'h1C000000, 1'b0, '0);
      chk("stall_idle_valid", {{W{1'b0}}, IF_pd_valid}, '0);

      @(negedge clk);
      #1;
      chk("queue_drained", (W+1)'(exp_q.size()), '0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
      $finish;
   end

endmodule

// File: doc/branch_predictor.md
# branch_predictor

Fetch-side branch predictor that consumes the per-cycle resolution/update stream from the EX-stage branch unit (PC of the branch, predictor type, target, taken) and produces registered predictions for a two-instruction fetch group. The predictions are the `br_pd` / `pc_pd` / `pd_type` values carried down the pipeline to EX. It holds a direct-mapped BTB with a 2-bit saturating counter per entry. It sits between the IF PC generator and the IF/ID pipeline register.

## Interface
- BTB_IDX_W, 6, index bits; the BTB has 2^BTB_IDX_W entries.
- TAG_W, 8, tag bits taken from the PC above the index.

- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- IF_pc  in  32  fetch-group PC, word-aligned; slot a = IF_pc, slot b = IF_pc+4
- IF_req  in  1  capture IF_pc this cycle
- IF_stall  in  1  hold all prediction outputs; overrides IF_req
- EX_pc_of_br  in  32  PC of the resolved branch
- EX_pd_type  in  2  update type: 00 none, 01 conditional, 10 direct unconditional, 11 indirect (jirl)
- EX_br_target  in  32  resolved target
- EX_br_jump  in  1  resolved taken
- IF_pd_valid  out  1  prediction outputs correspond to a captured request
- IF_br_pd_a, IF_br_pd_b  out  1  predicted taken for slot a / slot b
- IF_pc_pd_a, IF_pc_pd_b  out  32  predicted next PC for slot a / slot b
- IF_pd_type_a, IF_pd_type_b  out  2  BTB-recorded type on a hit, otherwise 00
- IF_npc  out  32  next fetch-group PC

## Operation
- **Index and tag.** idx = pc[BTB_IDX_W+1:2]; tag = pc[TAG_W+BTB_IDX_W+1:BTB_IDX_W+2].
- **Entry contents.** valid, tag, target[31:0], type[1:0], cnt[1:0].
- **Lookup (slots a and b in parallel, two read ports).**
  - hit = valid & tag match.
  - taken = hit & cnt[1].
  - pc_pd = taken ? target : slot_pc+4.
  - pd_type = hit ? type : 00.
- **Slot a taken suppresses slot b.** If slot a is predicted taken: IF_br_pd_b=0, IF_pd_type_b=00, IF_pc_pd_b=IF_pc+8.
- **Next fetch PC.** IF_npc = br_pd_a ? pc_pd_a : br_pd_b ? pc_pd_b : IF_pc+8, computed mod 2^32. Wrap-around is allowed; 0xFFFFFFFC+4 = 0x00000000.
- **Update.** An update happens whenever EX_pd_type != 00, independent of IF_stall. Let U = entry at idx(EX_pc_of_br).
  - **Hit, type 01:** cnt saturating +1 if EX_br_jump, else saturating −1. Target and type are rewritten with the EX values.
  - **Hit, type 10/11:** cnt = 11; target and type are rewritten.
  - **Miss, EX_br_jump=1:** allocate (overwrite U): valid=1, tag, target, type. cnt = 10 for type 01, 11 otherwise.
  - **Miss, EX_br_jump=0:** no change. Never-taken branches are not allocated.
- **No pipeline flush input.** Mispredict recovery is done by EX redirecting IF_pc.

## Timing
- **Lookup latency.** One cycle. A request is captured at the rising edge where IF_req=1 and IF_stall=0, and outputs are valid after that edge with IF_pd_valid=1.
- **No request.** At an edge with IF_req=0 and IF_stall=0, IF_pd_valid goes to 0. The other outputs keep their last values but are don't-care.
- **Stall.** IF_stall=1 freezes every output register, including IF_pd_valid.
- **Update latency.** The table write happens at the same edge the EX inputs are sampled. The first lookup that can see it is one captured at a later edge.
- **Simultaneous read and write of the same index.** The lookup returns the pre-update contents (read-before-write). The same rule holds for both slots.
- **Reset (asynchronous, takes effect immediately, including mid-operation).**
  - All valid bits = 0, all cnt = 01.
  - IF_pd_valid = 0, IF_br_pd_a/b = 0, IF_pd_type_a/b = 00, IF_pc_pd_a/b = 0, IF_npc = 0.
  - Any update in flight is lost.
- **Timing-path constraint.** No combinational path from any EX_* input to any output.

## Test plan
- **Reset.** Assert rst mid-run after allocations, deassert, then request IF_pc=0x1C000000 → IF_pd_valid=1, IF_br_pd_a=0, IF_pc_pd_a=0x1C000004, IF_npc=0x1C000008.
- **Allocate and saturate.**
  - Update {0x1C000010, type 01, target 0x1C000100, jump=1}, then request IF_pc=0x1C000010 → IF_br_pd_a=1, IF_pd_type_a=01, IF_pc_pd_a=IF_npc=0x1C000100, IF_br_pd_b=0, IF_pc_pd_b=0x1C000018.
  - Then two not-taken updates → cnt 10→01→00, and the request predicts not-taken.
- **Slot b and alias.**
  - Allocate type 10 at 0x1C000024, request IF_pc=0x1C000020 → IF_br_pd_a=0, IF_br_pd_b=1, IF_npc=target.
  - Request an alias PC with the same index and a different tag → miss, IF_pd_type_a=00.
- **Miss not-taken.** Update {type 01, jump=0} on an empty index → a subsequent lookup still misses.
- **Stall and collision.**
  - With outputs valid, hold IF_stall=1 for 3 cycles while changing IF_pc and issuing an update to the displayed index → outputs are unchanged.
  - Release the stall and re-request → the new contents are visible.
  - Same-edge request and update to one index → old contents are returned.
- **Wrap-around.** Request IF_pc=0xFFFFFFF8 with no hits → IF_pc_pd_b=0x00000000, IF_npc=0x00000000.
